// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: opcodes, FSM states,
// result-entry layout and the result normaliser.
package alu_op_sequencer_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_OR_RED  = 4'b0000;
    localparam logic [OP_W-1:0] OP_AND_RED = 4'b0001;
    localparam logic [OP_W-1:0] OP_XOR_RED = 4'b0010;
    localparam logic [OP_W-1:0] OP_AND     = 4'b0011;
    localparam logic [OP_W-1:0] OP_OR      = 4'b0100;
    localparam logic [OP_W-1:0] OP_XOR     = 4'b0101;
    localparam logic [OP_W-1:0] OP_EQ      = 4'b0110;
    localparam logic [OP_W-1:0] OP_LT      = 4'b0111;
    localparam logic [OP_W-1:0] OP_GT      = 4'b1000;
    localparam logic [OP_W-1:0] OP_ZERO    = 4'b1001;
    localparam logic [OP_W-1:0] OP_ADD     = 4'b1010;
    localparam logic [OP_W-1:0] OP_SUB     = 4'b1011;
    localparam logic [OP_W-1:0] OP_MUL     = 4'b1100;
    localparam logic [OP_W-1:0] OP_SHL     = 4'b1101;
    localparam logic [OP_W-1:0] OP_ROT     = 4'b1110;
    localparam logic [OP_W-1:0] OP_NOT     = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] y;
        logic [DATA_W-1:0] x;
    } res_entry_t;

    localparam int unsigned ENTRY_W = $bits(res_entry_t);

    // Clear result bits the ALU leaves undriven for the given opcode.
    function automatic res_entry_t normalise(input logic [OP_W-1:0]   op,
                                             input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] y);
        res_entry_t e;
        e.op = op;
        e.x  = x;
        e.y  = '0;
        case (op)
            OP_OR_RED, OP_AND_RED, OP_XOR_RED, OP_EQ, OP_LT, OP_GT, OP_ZERO:
                e.x = {{(DATA_W-1){1'b0}}, x[0]};
            OP_ADD:
                e.y = {{(DATA_W-1){1'b0}}, y[0]};
            OP_MUL, OP_SHL, OP_ROT:
                e.y = y;
            default: ;  // OP_AND/OR/XOR/SUB/NOT: full x, no y
        endcase
        return e;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Result FIFO with a registered head stage (first-word-fall-through).
// A pushed entry lands in storage and is promoted to the head on a later edge;
// a pop promotes the next stored entry on the same edge, so pops have no bubble.
// Ports: clk/rst (sync, active-high); push_i/data_i write side;
//        pop_i/valid_o/data_o head side; count_o total entries held.
module alu_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [DW-1:0]              data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [DW-1:0]              data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] mem_cnt_q, cnt_q;
    logic          head_vld_q;
    logic [DW-1:0] head_q;
    logic          pop, load;

    // Head is refilled from storage whenever it is empty or being popped.
    always_comb begin
        pop  = head_vld_q & pop_i;
        load = (~head_vld_q | pop) & (mem_cnt_q != '0);
    end

    // Storage array, no reset needed: only written entries are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            cnt_q      <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (load) begin
                rd_ptr_q   <= rd_ptr_q + AW'(1);
                head_q     <= mem_q[rd_ptr_q];
                head_vld_q <= 1'b1;
            end else if (pop) begin
                head_q     <= '0;
                head_vld_q <= 1'b0;
            end
            mem_cnt_q <= mem_cnt_q + CW'(push_i) - CW'(load);
            cnt_q     <= cnt_q + CW'(push_i) - CW'(pop);
        end
    end

    assign valid_o = head_vld_q;
    assign data_o  = head_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one request at a time to an external combinational ALU and queues
// the normalised results.
// Ports: clk/rst (sync, active-high); req_* request handshake and operands;
//        alu_a/alu_b/alu_op registered ALU inputs; alu_x/alu_y ALU results;
//        res_* result handshake with normalised x/y and opcode tag.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned W          = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic [3:0]   req_op,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [3:0]   alu_op,
    input  logic [W-1:0] alu_x,
    input  logic [W-1:0] alu_y,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_x,
    output logic [W-1:0] res_y,
    output logic [3:0]   res_op
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH+1);

    state_e       state_q, state_d;
    logic [W-1:0] alu_a_q, alu_b_q;
    logic [3:0]   alu_op_q;
    logic         accept, push;
    res_entry_t   push_entry, head_entry;
    logic [CNT_W-1:0] fifo_count;

    // Ready is masked during reset so nothing is accepted on the reset edge.
    assign req_ready = ~rst & (state_q == IDLE) & (fifo_count < CNT_W'(FIFO_DEPTH));

    // Next-state and handshake decode.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and issued-operand registers; operands hold until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_a_q  <= req_a;
                alu_b_q  <= req_b;
                alu_op_q <= req_op;
            end
        end
    end

    assign push_entry = normalise(alu_op_q, alu_x, alu_y);

    alu_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (res_ready),
        .valid_o (res_valid),
        .data_o  (head_entry),
        .count_o (fifo_count)
    );

    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign res_x  = head_entry.x;
    assign res_y  = head_entry.y;
    assign res_op = head_entry.op;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_alu_op_sequencer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [W-1:0] req_a, req_b;
    logic [3:0]   req_op;
    logic [W-1:0] alu_a, alu_b;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_x, alu_y;
    logic         res_valid, res_ready;
    logic [W-1:0] res_x, res_y;
    logic [3:0]   res_op;

    always #5 clk = ~clk;

    alu_op_sequencer #(.FIFO_DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_x(alu_x), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_x(res_x), .res_y(res_y), .res_op(res_op)
    );

    // Stand-in ALU: real results for add/mul, junk in undriven bits elsewhere.
    function automatic logic [7:0] alu_model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [7:0] r;
        s = 5'(a) + 5'(b);
        case (op)
            4'hC:    r = 8'(a) * 8'(b);
            4'hA:    r = {3'b101, s[4], s[3:0]};
            default: r = {4'(a + b + 4'h5), (a ^ b ^ op) | 4'b1110};
        endcase
        return r;
    endfunction

    // Which result bits survive for each opcode class, as a {y,x} mask.
    function automatic logic [7:0] exp_norm(input logic [3:0] op, input logic [7:0] raw);
        logic [7:0] keep;
        if (op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h8, 4'h9}) keep = 8'h01;
        else if (op == 4'hA)                                      keep = 8'h1F;
        else if (op inside {4'h3, 4'h4, 4'h5, 4'hB, 4'hF})        keep = 8'h0F;
        else                                                      keep = 8'hFF;
        return raw & keep;
    endfunction

    assign {alu_y, alu_x} = alu_model(alu_op, alu_a, alu_b);

    typedef struct {
        logic [3:0] op;
        logic [3:0] x;
        logic [3:0] y;
        int         rdy;
    } exp_t;

    exp_t       q[$];
    exp_t       pend;
    bit         busy;
    int         edge_n;
    logic [3:0] ea, eb, eop;
    int         checks;
    int         errors;
    logic       dut_ready_s;
    int         dut_acc;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs mid-cycle, then advance the model over the edge.
    task automatic cycle();
        logic       exp_ready, exp_valid, acc, pop;
        logic [3:0] hx, hy, hop;
        logic [7:0] nrm;
        @(negedge clk);
        exp_ready = !rst && !busy && (q.size() < DEPTH);
        exp_valid = (q.size() != 0) && (q[0].rdy <= edge_n);
        hx = '0; hy = '0; hop = '0;
        if (exp_valid) begin
            hx = q[0].x; hy = q[0].y; hop = q[0].op;
        end
        check("req_ready", 8'(req_ready), 8'(exp_ready));
        check("res_valid", 8'(res_valid), 8'(exp_valid));
        check("res_x",     8'(res_x),     8'(hx));
        check("res_y",     8'(res_y),     8'(hy));
        check("res_op",    8'(res_op),    8'(hop));
        check("alu_a",     8'(alu_a),     8'(ea));
        check("alu_b",     8'(alu_b),     8'(eb));
        check("alu_op",    8'(alu_op),    8'(eop));
        dut_ready_s = req_ready;
        acc = req_valid && exp_ready;
        pop = exp_valid && res_ready;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            q.delete();
            busy = 1'b0;
            ea = '0; eb = '0; eop = '0;
        end else begin
            if (pop) q.delete(0);
            if (busy) begin
                pend.rdy = edge_n + 1;
                q.push_back(pend);
            end
            busy = acc;
            if (acc) begin
                ea = req_a; eb = req_b; eop = req_op;
                nrm = exp_norm(req_op, alu_model(req_op, req_a, req_b));
                pend.op = req_op;
                pend.y  = nrm[7:4];
                pend.x  = nrm[3:0];
            end
        end
        #1;
    endtask

    task automatic issue_and_check(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                                   input logic [3:0] ex, input logic [3:0] ey, input string tag);
        res_ready = 1'b1;
        req_valid = 1'b0;
        repeat (6) cycle();
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        cycle();
        req_valid = 1'b0; req_a = 4'h0; req_b = 4'h0; req_op = 4'h0;
        res_ready = 1'b0;
        cycle();
        check({tag, "_valid_edge1"}, 8'(res_valid), 8'h0);
        cycle();
        check({tag, "_valid_edge2"}, 8'(res_valid), 8'h1);
        check({tag, "_x"},  8'(res_x),  8'(ex));
        check({tag, "_y"},  8'(res_y),  8'(ey));
        check({tag, "_op"}, 8'(res_op), 8'(op));
    endtask

    initial begin
        checks = 0; errors = 0; edge_n = 0; busy = 1'b0;
        ea = '0; eb = '0; eop = '0;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; res_ready = 1'b0;
        @(posedge clk); #1;
        cycle();
        check("reset_ready", 8'(req_ready), 8'h0);
        rst = 1'b0;
        cycle();
        check("ready_after_reset", 8'(req_ready), 8'h1);

        // Latency and normalisation of specific ops.
        issue_and_check(4'hF, 4'hF, 4'hC, 4'h1, 4'hE, "mul");
        issue_and_check(4'h9, 4'h8, 4'hA, 4'h1, 4'h1, "add");
        issue_and_check(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, "red");

        // Fill FIFO with no consumer, then single pop.
        res_ready = 1'b1;
        repeat (4) cycle();
        res_ready = 1'b0;
        req_valid = 1'b1;
        dut_acc = 0;
        for (int i = 0; i < 8; i++) begin
            req_a = 4'($urandom); req_b = 4'($urandom); req_op = 4'($urandom);
            cycle();
            if (dut_ready_s) dut_acc++;
        end
        check("full_accepts", 8'(dut_acc), 8'd4);
        check("full_ready", 8'(req_ready), 8'h0);
        repeat (2) begin
            req_a = 4'($urandom); req_op = 4'($urandom);
            cycle();
        end
        check("full_hold_valid", 8'(res_valid), 8'h1);
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        check("ready_after_pop", 8'(req_ready), 8'h1);
        cycle();                 // accept at count 3
        req_valid = 1'b0;
        res_ready = 1'b1;
        cycle();                 // push and pop on the same edge
        res_ready = 1'b0;
        check("pushpop_ready", 8'(req_ready), 8'h1);
        res_ready = 1'b1;
        repeat (8) cycle();

        // Reset while an op is executing, and reset with a loaded FIFO.
        req_valid = 1'b1; req_a = 4'h7; req_b = 4'h3; req_op = 4'hC;
        res_ready = 1'b0;
        cycle();
        req_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_exec_valid", 8'(res_valid), 8'h0);
        check("rst_exec_a",     8'(alu_a),     8'h0);
        check("rst_exec_b",     8'(alu_b),     8'h0);
        check("rst_exec_op",    8'(alu_op),    8'h0);
        repeat (3) cycle();
        check("rst_exec_nopush", 8'(res_valid), 8'h0);
        req_valid = 1'b1;
        repeat (6) cycle();
        rst = 1'b1;
        req_valid = 1'b0;
        cycle();
        rst = 1'b0;
        check("rst_flush_valid", 8'(res_valid), 8'h0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_a     = 4'($urandom);
            req_b     = 4'($urandom);
            req_op    = 4'($urandom);
            if ((i % 100) < 40) res_ready = ($urandom_range(0, 4) == 0);
            else                res_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b1;
        repeat (12) cycle();
        check("drain_empty", 8'(res_valid), 8'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
